// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response and word-RAM signals of the MEM-stage load/store unit.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        ram_wen;
  logic        ram_ren;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ram_wen, ram_ren, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ram_wen, ram_ren, ram_addr, ram_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit: sub-word load extraction, read-modify-write sub-word stores and
// request checking in front of a word-wide RAM with one-cycle read latency.
module lsu_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [32:0] AddrLimit = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] merge_q, merge_d;

  logic        accept;
  logic        legal;
  logic        misalign;
  logic        out_of_range;
  logic        req_err;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.req_we;
      default:                legal = 1'b0;
    endcase

    misalign = 1'b0;
    if (bus.req_funct3[1:0] == 2'b01) begin
      misalign = bus.req_addr[0];
    end else if (bus.req_funct3[1:0] == 2'b10) begin
      misalign = |bus.req_addr[1:0];
    end

    out_of_range = {1'b0, bus.req_addr} >= AddrLimit;
    req_err      = !legal || misalign || out_of_range;
  end

  // Lane selection and merge both work on the word returned in CAP.
  always_comb begin
    sel_byte = bus.ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    sel_half = bus.ram_rdata[{addr_q[1], 4'b0000} +: 16];

    case (f3_q)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_val = {24'h0, sel_byte};
      3'b101:  load_val = {16'h0, sel_half};
      default: load_val = bus.ram_rdata;
    endcase

    merge_val = bus.ram_rdata;
    if (f3_q[0] == 1'b0) begin
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rdata_d = '0;
          if (req_err) begin
            state_d = StResp;
          end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        if (we_q) begin
          merge_d = merge_val;
          state_d = StWr;
        end else begin
          rdata_d = load_val;
          state_d = StResp;
        end
      end
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
      end
    end
  end

  // RAM strobes come straight from state so an async reset drops them at once.
  assign bus.req_ready  = (state_q == StIdle) && !rst;
  assign bus.ram_ren    = (state_q == StRd);
  assign bus.ram_wen    = (state_q == StWr);
  assign bus.ram_addr   = {addr_q[31:2], 2'b00};
  assign bus.ram_wdata  = (f3_q == 3'b010) ? wdata_q : merge_q;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_err   = bus.resp_valid && err_q;
  assign bus.resp_rdata = bus.resp_valid ? rdata_q : '0;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit for the MEM stage. Sits directly upstream of the word-wide data RAM and turns RV32I load/store requests into RAM word accesses.
- Loads: performs byte/halfword extraction with sign or zero extension.
- Stores: sub-word stores use read-modify-write, because the RAM only writes whole words.
- Checks every request for misalignment, illegal funct3 and out-of-range addresses.
- Returns one response per request to the pipeline.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the attached RAM; byte addresses >= DEPTH_WORDS*4 are out of range.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width/sign code
req_addr  input  32  byte address
req_wdata  input  32  store data (low bits used for SB/SH)
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  request rejected (misaligned, illegal, out of range)
ram_wen  output  1  RAM write enable
ram_ren  output  1  RAM read enable
ram_addr  output  32  RAM byte address, always word-aligned ({a[31:2],2'b00})
ram_wdata  output  32  RAM write word
ram_rdata  input  32  RAM read data, valid the cycle after ram_ren

Behaviour:
- Reset values: state IDLE; resp_valid=0, resp_rdata=0, resp_err=0. ram_wen=0 and ram_ren=0 immediately on rst assertion (asynchronous). req_ready=0 while rst is high.
- Handshake:
  - req_ready = (state==IDLE) && !rst.
  - A request is accepted on the clk edge where req_valid && req_ready; all req_* fields are latched into internal registers at that edge.
  - One outstanding request at a time. Responses cannot be back-pressured.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Error conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Illegal funct3.
  - addr >= DEPTH_WORDS*4.
  - Any error: IDLE -> RESP with resp_err=1, resp_rdata=0; ram_ren and ram_wen never asserted.
- States (RAM outputs are decoded from state plus latched registers):
  - IDLE: waits for accept. LW or any load -> RD. SB/SH -> RD. SW -> WR. Error -> RESP.
  - RD: ram_ren=1, ram_addr = word address. Always -> CAP.
  - CAP: ram_rdata is valid.
    - Load: extract the byte (addr[1:0]) or halfword (addr[1]), sign- or zero-extend, register into resp_rdata, -> RESP.
    - Store: merge the wdata byte/half into the read word at the addressed lane, register as merge word, -> WR.
  - WR: ram_wen=1, ram_addr = word address. ram_wdata = merge word (SB/SH) or latched wdata (SW). -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, with resp_err/resp_rdata. -> IDLE.
- Latency, counted as the number of cycles after the accept edge at which resp_valid is high:
  - Error: 1.
  - SW: 2.
  - Loads: 3.
  - SB/SH: 4.
  - The next request can be accepted on the edge that leaves RESP.
- RAM access counts per request:
  - Each store produces exactly one ram_wen cycle.
  - Each load or sub-word store produces exactly one ram_ren cycle.
  - ram_wen and ram_ren are never high together.
- Reset mid-operation: the operation is aborted with no response. If rst rises before the WR edge, no RAM write occurs. After rst falls the block returns to IDLE.

Test Plan:
1. Preload word 0x10 = 0x8899AABB. LB 0x13 -> resp_rdata 0xFFFFFF88; LBU 0x13 -> 0x00000088. Each resp_valid 3 cycles after accept, resp_err=0.
2. Same preload. LH 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB; LW 0x10 -> 0x8899AABB.
3. SB addr 0x11, wdata 0x123456CC. Required:
   - One ram_ren cycle, then one ram_wen cycle with ram_wdata 0x8899CCBB and ram_addr 0x10.
   - resp_valid 4 cycles after accept.
   - Subsequent LW 0x10 returns 0x8899CCBB.
4. SW 0x20 0xDEADBEEF -> no ram_ren, one ram_wen, resp_valid 2 cycles after accept. Then SH 0x22 0x0000CAFE followed by LW 0x20 -> 0xCAFEBEEF.
5. Each of the following -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, no RAM enables:
   - LH 0x11
   - SW 0x22
   - load funct3=011
   - LW 0x1000 with DEPTH_WORDS=1024
6. Assert rst during CAP of SH 0x10 -> ram_wen never asserts, word unchanged, no resp_valid. After rst falls, req_ready=1 and the next LW completes normally.
